fifo_stream_reader: RTL and testbench

Drain side of the sniffer's 64-bit capture FIFO. Pops words from a standard (non-FWFT, 1-cycle read latency) FIFO read port and presents them as an AXI4-Stream master with full valid/ready handshaking, packetising the stream with `m_tlast` every `PKT_LEN` beats. It sits between the capture FIFO and the DMA / stream sink. It absorbs FIFO read latency and downstream back-pressure in a 2-entry output buffer, so it sustains 1 beat/cycle.

---
 rtl/sniffer_pkg.sv | 23 ++
 rtl/stream_skid_buf.sv | 79 +++++++
 rtl/fifo_stream_reader.sv | 113 +++++++++++
 tb/tb_fifo_stream_reader.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sniffer_pkg.sv
// ============================================================================
// sniffer_pkg : shared types and defaults for the capture-FIFO drain path
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package sniffer_pkg;

    localparam int DATA_W_DEFAULT  = 64;
    localparam int PKT_LEN_DEFAULT = 256;

    typedef logic [63:0] data_t;

    // Encoded so that the state value equals the buffer occupancy.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

endpackage

`default_nettype wire

// File: rtl/stream_skid_buf.sv
// ============================================================================
// stream_skid_buf : 2-entry output buffer presenting captured words as an
//                   AXI4-Stream source (head/second registers + occupancy FSM)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module stream_skid_buf
    import sniffer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              cap_valid,
    input  logic [DATA_W-1:0] cap_data,
    input  logic              m_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    output logic [1:0]        occ
);

    buf_state_e        state_q, state_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] second_q, second_d;
    logic              w_xfer;

    assign m_tvalid = (state_q != EMPTY);
    assign m_tdata  = head_q;
    assign occ      = state_q;
    assign w_xfer   = m_tvalid && m_tready;

    always_comb begin
        state_d  = state_q;
        head_d   = head_q;
        second_d = second_q;
        case (state_q)
            EMPTY: begin
                if (cap_valid) begin
                    head_d  = cap_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (cap_valid && w_xfer) begin
                    head_d = cap_data;
                end else if (cap_valid) begin
                    second_d = cap_data;
                    state_d  = FULL;
                end else if (w_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // The pop rule in the parent keeps captures away from FULL.
                if (w_xfer) begin
                    head_d  = second_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q  <= EMPTY;
            head_q   <= '0;
            second_q <= '0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            second_q <= second_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_stream_reader.sv
// ============================================================================
// fifo_stream_reader : drains a 1-cycle-latency FIFO into a packetised
//                      AXI4-Stream; optional counters via FIFO_READER_STATS_EN
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module fifo_stream_reader
    import sniffer_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int PKT_LEN = PKT_LEN_DEFAULT
) (
    input  logic                clk,
    input  logic                arst,
    input  logic                fifo_empty,
    output logic                fifo_rd_en,
    input  logic [DATA_W-1:0]   fifo_dout,
    output logic [DATA_W-1:0]   m_tdata,
    output logic [DATA_W/8-1:0] m_tkeep,
    output logic                m_tlast,
    output logic                m_tvalid,
    input  logic                m_tready
`ifdef FIFO_READER_STATS_EN
    ,
    output logic [31:0]         beat_cnt,
    output logic [31:0]         pkt_cnt
`endif
);

    localparam int                c_idx_w    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(PKT_LEN - 1);

    logic               inflight_q, inflight_d;
    logic [c_idx_w-1:0] idx_q, idx_d;
    logic [1:0]         w_occ;
    logic [2:0]         w_pending;
    logic               w_xfer;

    stream_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .arst      (arst),
        .cap_valid (inflight_q),
        .cap_data  (fifo_dout),
        .m_tready  (m_tready),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .occ       (w_occ)
    );

    assign w_xfer    = m_tvalid && m_tready;
    // Words already owned (buffered + in flight) after this cycle's transfer.
    assign w_pending = {1'b0, w_occ} + {2'b00, inflight_q} - {2'b00, w_xfer};
    assign fifo_rd_en = !arst && !fifo_empty && (w_pending < 3'd2);

    assign m_tlast = m_tvalid && (idx_q == c_last_idx);
    assign m_tkeep = {(DATA_W/8){m_tvalid}};

    always_comb begin
        inflight_d = fifo_rd_en;
        idx_d      = idx_q;
        if (w_xfer) begin
            idx_d = (idx_q == c_last_idx) ? '0 : idx_q + c_idx_w'(1);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            inflight_q <= 1'b0;
            idx_q      <= '0;
        end else begin
            inflight_q <= inflight_d;
            idx_q      <= idx_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (arst)
        ({1'b0, w_occ} + {2'b00, inflight_q}) <= 3'd2);

`ifdef FIFO_READER_STATS_EN
    logic [31:0] beat_cnt_q, beat_cnt_d;
    logic [31:0] pkt_cnt_q, pkt_cnt_d;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        if (w_xfer) begin
            beat_cnt_d = beat_cnt_q + 32'd1;
            if (m_tlast) begin
                pkt_cnt_d = pkt_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            beat_cnt_q <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    assign beat_cnt = beat_cnt_q;
    assign pkt_cnt  = pkt_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
// ============================================================================
// tb_fifo_stream_reader : directed bench for fifo_stream_reader (PKT_LEN=4,
//                         plus a PKT_LEN=1 instance sharing the same inputs)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_fifo_stream_reader;

    localparam int DW    = 64;
    localparam int PL    = 4;
    localparam int DEPTH = 8192;

    logic          clk        = 1'b0;
    logic          arst       = 1'b1;
    logic          hold_empty = 1'b0;
    logic          m_tready   = 1'b0;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_dout  = '0;
    logic [DW-1:0] m_tdata;
    logic [7:0]    m_tkeep;
    logic          m_tlast;
    logic          m_tvalid;
    logic          rd1, last1, valid1;
    logic [DW-1:0] data1;
    logic [7:0]    keep1;
`ifdef FIFO_READER_STATS_EN
    logic [31:0]   beat_cnt, pkt_cnt, beat_cnt1, pkt_cnt1;
`endif

    logic [DW-1:0] mem [DEPTH];
    int fifo_wr = 0;
    int fifo_rd = 0;
    int pop_cnt = 0;
    int xfer_cnt = 0, exp_ptr = 0, midx = 0, m_pkts = 0;
    int tests = 0, fails = 0;

    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic          prev_last  = 1'b0;

    always #5 clk = ~clk;

    fifo_stream_reader #(.DATA_W(DW), .PKT_LEN(PL)) u_dut (
        .clk        (clk),
        .arst       (arst),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .m_tdata    (m_tdata),
        .m_tkeep    (m_tkeep),
        .m_tlast    (m_tlast),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready)
`ifdef FIFO_READER_STATS_EN
        ,
        .beat_cnt   (beat_cnt),
        .pkt_cnt    (pkt_cnt)
`endif
    );

    fifo_stream_reader #(.DATA_W(DW), .PKT_LEN(1)) u_dut1 (
        .clk        (clk),
        .arst       (arst),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (rd1),
        .fifo_dout  (fifo_dout),
        .m_tdata    (data1),
        .m_tkeep    (keep1),
        .m_tlast    (last1),
        .m_tvalid   (valid1),
        .m_tready   (m_tready)
`ifdef FIFO_READER_STATS_EN
        ,
        .beat_cnt   (beat_cnt1),
        .pkt_cnt    (pkt_cnt1)
`endif
    );

    // FIFO model: standard read port, data one cycle after the pop.
    assign fifo_empty = hold_empty || (fifo_rd == fifo_wr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_dout <= mem[fifo_rd % DEPTH];
            fifo_rd   <= fifo_rd + 1;
        end
        pop_cnt <= arst ? 0 : pop_cnt + (fifo_rd_en ? 1 : 0);
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] v);
        mem[fifo_wr % DEPTH] = v;
        fifo_wr++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_xfers(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (xfer_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (xfer_cnt < target) chk(tag, 64'(xfer_cnt), 64'(target));
    endtask

    // Stream monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (arst) begin
            exp_ptr    = fifo_rd;
            midx       = 0;
            xfer_cnt   = 0;
            m_pkts     = 0;
            prev_stall = 1'b0;
        end else begin
            chk("outstanding_le_2", 64'(pop_cnt - xfer_cnt <= 2), 64'd1);
            if (prev_stall) begin
                chk("stall_hold_data", m_tdata, prev_data);
                chk("stall_hold_last", 64'(m_tlast), 64'(prev_last));
            end
            chk("tkeep", 64'(m_tkeep), m_tvalid ? 64'hFF : 64'h0);
            chk("tlast_position", 64'(m_tlast), 64'(m_tvalid && (midx == PL - 1)));
            chk("p1_valid", 64'(valid1), 64'(m_tvalid));
            chk("p1_rd_en", 64'(rd1), 64'(fifo_rd_en));
            chk("p1_tlast", 64'(last1), 64'(m_tvalid));
            chk("p1_tkeep", 64'(keep1), 64'(m_tkeep));
            if (m_tvalid) chk("p1_tdata", data1, m_tdata);
            if (m_tvalid && m_tready) begin
                chk("data_order", m_tdata, mem[exp_ptr % DEPTH]);
                if (m_tlast) m_pkts++;
                exp_ptr++;
                xfer_cnt++;
                midx = (midx == PL - 1) ? 0 : midx + 1;
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
        end
    end

    initial begin
        #5ms;
        $error("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pop_k, val_k, last_k, n, base, pk;
        logic [3:0] pat;

        // ---- reset values ----
        m_tready = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_rd_en",  64'(fifo_rd_en), 64'd0);
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_tlast",  64'(m_tlast), 64'd0);
        chk("rst_tdata",  m_tdata, 64'd0);
        chk("rst_tkeep",  64'(m_tkeep), 64'd0);

        // ---- 4 words, latency and back-to-back beats ----
        for (int i = 1; i <= 4; i++) push(64'(i));
        tick();
        arst = 1'b0;
        pop_k = -1; val_k = -1; last_k = -1; n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (fifo_rd_en && pop_k < 0) pop_k = k;
            if (m_tvalid && val_k < 0) val_k = k;
            if (m_tvalid && m_tready) begin
                n++;
                last_k = k;
            end
        end
        chk("first_pop_cycle", 64'(pop_k), 64'd0);
        chk("first_valid_latency", 64'(val_k - pop_k), 64'd2);
        chk("four_beats", 64'(n), 64'd4);
        chk("beats_consecutive", 64'(last_k - val_k), 64'd3);
        chk("idle_after_4", 64'(m_tvalid), 64'd0);

        // ---- 10 words, PKT_LEN 4 ----
        tick();
        base = xfer_cnt;
        pk   = m_pkts;
        for (int i = 0; i < 10; i++) push(64'h11 + 64'(i));
        wait_xfers(base + 10, 60, "timeout_10_words");
        repeat (3) @(negedge clk);
        chk("pkts_in_10", 64'(m_pkts - pk), 64'd2);
        chk("open_pkt_no_valid", 64'(m_tvalid), 64'd0);
        chk("open_pkt_no_last", 64'(m_tlast), 64'd0);
        chk("empty_no_pop", 64'(fifo_rd_en), 64'd0);
`ifdef FIFO_READER_STATS_EN
        chk("beat_cnt_14", 64'(beat_cnt), 64'd14);
        chk("pkt_cnt_3", 64'(pkt_cnt), 64'd3);
        chk("p1_pkt_cnt_14", 64'(pkt_cnt1), 64'd14);
`endif

        // ---- back-pressure, ready pattern 1,0,0,1 ----
        tick();
        base = xfer_cnt;
        for (int i = 0; i < 64; i++) push(64'h100 + 64'(i));
        pat = 4'b1001;
        n = 0;
        while (xfer_cnt < base + 64 && n < 400) begin
            m_tready = pat[n % 4];
            tick();
            n++;
        end
        m_tready = 1'b1;
        repeat (4) @(negedge clk);
        chk("bp_beats_64", 64'(xfer_cnt - base), 64'd64);
        chk("bp_idle", 64'(m_tvalid), 64'd0);
`ifdef FIFO_READER_STATS_EN
        chk("beat_cnt_78", 64'(beat_cnt), 64'd78);
        chk("pkt_cnt_19", 64'(pkt_cnt), 64'd19);
`endif

        // ---- random empty / ready ----
        tick();
        for (int k = 0; k < 3000; k++) begin
            hold_empty = ($urandom_range(0, 3) == 0);
            m_tready   = 1'($urandom_range(0, 1));
            if (fifo_wr - fifo_rd < 6) push(64'hA5A5_0000_0000_0000 | 64'(k));
            tick();
        end
        hold_empty = 1'b0;
        m_tready   = 1'b1;
        wait_xfers(fifo_wr, 100, "timeout_random_drain");
        chk("random_all_delivered", 64'(xfer_cnt), 64'(fifo_wr));

        // ---- reset mid-packet with a full buffer ----
        tick();
        for (int i = 0; i < 20; i++) push(64'h2000 + 64'(i));
        n = 0;
        while (midx != 1 && n < 20) begin
            tick();
            n++;
        end
        m_tready = 1'b0;
        repeat (4) @(negedge clk);
        chk("full_valid", 64'(m_tvalid), 64'd1);
        chk("full_no_pop", 64'(fifo_rd_en), 64'd0);
        chk("full_mid_pkt_last", 64'(m_tlast), 64'd0);
        @(posedge clk);
        #2;
        arst = 1'b1;
        #1;
        chk("arst_rd_en",  64'(fifo_rd_en), 64'd0);
        chk("arst_tvalid", 64'(m_tvalid), 64'd0);
        chk("arst_tlast",  64'(m_tlast), 64'd0);
        chk("arst_tdata",  m_tdata, 64'd0);
        chk("arst_tkeep",  64'(m_tkeep), 64'd0);
        repeat (2) tick();
        arst     = 1'b0;
        m_tready = 1'b1;
        wait_xfers(8, 60, "timeout_after_reset");
        chk("pkts_after_reset", 64'(m_pkts), 64'd2);
        repeat (30) @(negedge clk);
        chk("post_reset_drained", 64'(m_tvalid), 64'd0);
`ifdef FIFO_READER_STATS_EN
        chk("beat_cnt_after_reset", 64'(beat_cnt), 64'(xfer_cnt));
        chk("pkt_cnt_after_reset", 64'(pkt_cnt), 64'(m_pkts));
`endif

        // ---- sustained throughput ----
        tick();
        arst = 1'b1;
        for (int i = 0; i < 1100; i++) push(64'h3_0000 + 64'(i));
        repeat (2) tick();
        arst = 1'b0;
        n = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (m_tvalid && m_tready) n++;
        end
        chk("sustained_998", 64'(n), 64'd998);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
